pmp_csr_initiator: RTL

//  Requester side of the PMP CSR access port. Accepts one decoded Zicsr instruction at a time from
//  the issue stage and drives a single-cycle request into the pmp block. Captures read data and the

---
 rtl/pmp_csr_initiator_if.sv | 58 +++++
 rtl/pmp_csr_initiator.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pmp_csr_initiator_if.sv
// Bundle of signals between the CSR initiator, the issue/execute pipe and the pmp CSR port.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready are both 1.
// A valid, once raised, is held with its payload stable until that edge, unless flush
// withdraws it. ready may change freely and never waits on valid. inst_valid/inst_ready
// carries instructions in; wb_valid/wb_ready carries the rd writeback out. The pmp
// request (csr_req_en) and the exception (exc_valid) are single-cycle strobes with no ready.
interface pmp_csr_initiator_if #(
    parameter int REG_WIDTH    = 32,
    parameter int RD_IDX_WIDTH = 5
);
    // instruction from the issue stage
    logic                    inst_valid;
    logic                    inst_ready;
    logic [2:0]              inst_funct3;
    logic [4:0]              inst_rs1_idx;
    logic [REG_WIDTH-1:0]    inst_rs1_val;
    logic [11:0]             inst_csr_addr;
    logic [RD_IDX_WIDTH-1:0] inst_rd_idx;
    logic                    flush;

    // request/response with the pmp CSR port
    logic                    csr_req_en;
    logic [1:0]              csr_req_op;
    logic [2:0]              csr_funct3;
    logic [4:0]              csr_imm;
    logic [REG_WIDTH-1:0]    rs1_val;
    logic [11:0]             csr_req_addr;
    logic                    csr_rrsp;
    logic [31:0]             csr_req_rdata;
    logic                    csr_req_rvalid;
    logic                    csr_act_rsp;

    // writeback and exception towards the pipe
    logic                    wb_valid;
    logic                    wb_ready;
    logic [RD_IDX_WIDTH-1:0] wb_rd_idx;
    logic [REG_WIDTH-1:0]    wb_data;
    logic                    exc_valid;
    logic [3:0]              exc_cause;
    logic [REG_WIDTH-1:0]    exc_tval;

    modport master (
        input  inst_valid, inst_funct3, inst_rs1_idx, inst_rs1_val, inst_csr_addr,
               inst_rd_idx, flush, csr_req_rdata, csr_req_rvalid, csr_act_rsp, wb_ready,
        output inst_ready, csr_req_en, csr_req_op, csr_funct3, csr_imm, rs1_val,
               csr_req_addr, csr_rrsp, wb_valid, wb_rd_idx, wb_data, exc_valid,
               exc_cause, exc_tval
    );

    modport slave (
        output inst_valid, inst_funct3, inst_rs1_idx, inst_rs1_val, inst_csr_addr,
               inst_rd_idx, flush, csr_req_rdata, csr_req_rvalid, csr_act_rsp, wb_ready,
        input  inst_ready, csr_req_en, csr_req_op, csr_funct3, csr_imm, rs1_val,
               csr_req_addr, csr_rrsp, wb_valid, wb_rd_idx, wb_data, exc_valid,
               exc_cause, exc_tval
    );
endinterface

// File: rtl/pmp_csr_initiator.sv
// Requester side of the PMP CSR access port: takes one Zicsr instruction at a time,
// issues a single-cycle request to the pmp, acknowledges its read data and returns
// either an rd writeback or an illegal-instruction exception.
module pmp_csr_initiator #(
    parameter int PMP_CHANNEL_NUM = 32,
    parameter int REG_WIDTH       = 32,
    parameter int RD_IDX_WIDTH    = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pmp_csr_initiator_if.master   bus,
    output logic [1:0]            state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_ACK  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // legal windows: pmpcfg holds four entries per register, pmpaddr one per register
    localparam logic [31:0] CFG_FIRST  = 32'h3A0;
    localparam logic [31:0] CFG_END    = CFG_FIRST + 32'(PMP_CHANNEL_NUM / 4);
    localparam logic [31:0] ADDR_FIRST = 32'h3B0;
    localparam logic [31:0] ADDR_END   = ADDR_FIRST + 32'(PMP_CHANNEL_NUM);
    localparam logic [3:0]  CAUSE_ILLEGAL = 4'd2;

    function automatic logic addr_in_range(input logic [11:0] a);
        logic [31:0] ai;
        ai = {20'd0, a};
        return ((ai >= CFG_FIRST) && (ai < CFG_END)) || ((ai >= ADDR_FIRST) && (ai < ADDR_END));
    endfunction

    state_t                  state_q, state_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [4:0]              imm_q, imm_d;
    logic [REG_WIDTH-1:0]    rs1_val_q, rs1_val_d;
    logic [11:0]             addr_q, addr_d;
    logic [RD_IDX_WIDTH-1:0] rd_idx_q, rd_idx_d;
    logic                    rd_en_q, rd_en_d;
    logic                    wr_en_q, wr_en_d;
    logic                    illegal_q, illegal_d;
    logic                    act_q, act_d;
    logic                    kill_q, kill_d;
    logic [REG_WIDTH-1:0]    rdata_q, rdata_d;

    logic accept;
    logic is_rw;
    logic dec_rd_en;
    logic dec_wr_en;
    logic kill;
    logic exc_cond;
    logic wb_pend;

    assign accept = (state_q == S_IDLE) && !bus.flush && bus.inst_valid;

    // CSRRW/CSRRWI skip the read when rd is x0; the set/clear forms always read,
    // because the pmp builds their write data from the old value.
    assign is_rw     = (bus.inst_funct3[1:0] == 2'b01);
    assign dec_wr_en = is_rw || (bus.inst_rs1_idx != 5'd0);
    assign dec_rd_en = !is_rw || (bus.inst_rd_idx != '0);

    // a flush seen at any point after accept kills the architectural result only
    assign kill     = kill_q || bus.flush;
    assign exc_cond = illegal_q || act_q;
    assign wb_pend  = rd_en_q && (rd_idx_q != '0) && !exc_cond;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state: REQ and ACK always run to completion since the pmp has committed
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = addr_in_range(bus.inst_csr_addr) ? S_REQ : S_DONE;
            S_REQ:  state_d = rd_en_q ? S_ACK : S_DONE;
            S_ACK:  state_d = S_DONE;
            S_DONE: if (!wb_pend || kill || bus.wb_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.inst_ready = (state_q == S_IDLE) && !bus.flush;
        bus.csr_req_en = (state_q == S_REQ);
        bus.csr_req_op = (state_q == S_REQ) ? {rd_en_q, wr_en_q} : 2'b00;
        bus.csr_rrsp   = (state_q == S_ACK);
        bus.exc_valid  = (state_q == S_DONE) && exc_cond && !kill;
        bus.wb_valid   = (state_q == S_DONE) && wb_pend && !kill;
        bus.exc_cause  = bus.exc_valid ? CAUSE_ILLEGAL : 4'd0;
        bus.exc_tval   = bus.exc_valid ? REG_WIDTH'(addr_q) : '0;
    end

    assign bus.csr_funct3   = funct3_q;
    assign bus.csr_imm      = imm_q;
    assign bus.rs1_val      = rs1_val_q;
    assign bus.csr_req_addr = addr_q;
    assign bus.wb_rd_idx    = rd_idx_q;
    assign bus.wb_data      = rdata_q;
    assign state_o          = state_q;

    // datapath next-state: capture the instruction at accept, the pmp response in REQ
    always_comb begin
        funct3_d  = funct3_q;
        imm_d     = imm_q;
        rs1_val_d = rs1_val_q;
        addr_d    = addr_q;
        rd_idx_d  = rd_idx_q;
        rd_en_d   = rd_en_q;
        wr_en_d   = wr_en_q;
        illegal_d = illegal_q;
        act_d     = act_q;
        kill_d    = kill_q;
        rdata_d   = rdata_q;
        if (accept) begin
            funct3_d  = bus.inst_funct3;
            imm_d     = bus.inst_rs1_idx;
            rs1_val_d = bus.inst_rs1_val;
            addr_d    = bus.inst_csr_addr;
            rd_idx_d  = bus.inst_rd_idx;
            rd_en_d   = dec_rd_en;
            wr_en_d   = dec_wr_en;
            illegal_d = !addr_in_range(bus.inst_csr_addr);
            act_d     = 1'b0;
            kill_d    = 1'b0;
            rdata_d   = '0;
        end else begin
            if ((state_q != S_IDLE) && bus.flush) kill_d = 1'b1;
            if (state_q == S_REQ) begin
                act_d = bus.csr_act_rsp;
                if (bus.csr_req_rvalid) rdata_d = REG_WIDTH'(bus.csr_req_rdata);
            end
        end
    end

    // datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct3_q  <= '0;
            imm_q     <= '0;
            rs1_val_q <= '0;
            addr_q    <= '0;
            rd_idx_q  <= '0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            illegal_q <= 1'b0;
            act_q     <= 1'b0;
            kill_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            funct3_q  <= funct3_d;
            imm_q     <= imm_d;
            rs1_val_q <= rs1_val_d;
            addr_q    <= addr_d;
            rd_idx_q  <= rd_idx_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            illegal_q <= illegal_d;
            act_q     <= act_d;
            kill_q    <= kill_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule
